// File: rtl/deploy_scheduler.sv
// deploy_scheduler
//   Queues deploy requests (fire button, tree timer, ...) as a saturating count.
//   On frame boundaries it issues a one-hot, one-clk deploy pulse to a bank of
//   NUM_SLOTS object instances, with a programmable cooldown in frames between
//   deploys. MODE=0 is the legacy blind round-robin. MODE=1 picks the first
//   free slot, starting at the round-robin pointer.
// Ports
//   clk, resetN      clock, synchronous active-low reset
//   startOfFrame     one-clk pulse per frame; service is evaluated only then
//   request          one-clk deploy request, accepted on any clk
//   rapid            picks COOLDOWN_RAPID rather than COOLDOWN_NORMAL at the next load
//   enable           0 flushes the queue and suppresses deploys
//   slot_busy        per-instance active flags
//   deploy           one-hot deploy pulse, valid for the clk after a frame clk
//   pending_cnt      number of queued requests
//   dropped          one-clk pulse when a request is lost because the queue is full
//   cooldown_active  cooldown counter is non-zero
module deploy_scheduler #(
    parameter int NUM_SLOTS       = 8,
    parameter int QUEUE_DEPTH     = 4,
    parameter int CD_W            = 8,
    parameter int COOLDOWN_NORMAL = 50,
    parameter int COOLDOWN_RAPID  = 20,
    parameter int MODE            = 1
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               startOfFrame,
    input  logic                               request,
    input  logic                               rapid,
    input  logic                               enable,
    input  logic [NUM_SLOTS-1:0]               slot_busy,
    output logic [NUM_SLOTS-1:0]               deploy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_cnt,
    output logic                               dropped,
    output logic                               cooldown_active
);
    localparam int PW = $clog2(QUEUE_DEPTH+1);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam logic [PW-1:0]   PEND_MAX  = PW'(QUEUE_DEPTH);
    localparam logic [CD_W-1:0] LOAD_N    = CD_W'(COOLDOWN_NORMAL - 1);
    localparam logic [CD_W-1:0] LOAD_R    = CD_W'(COOLDOWN_RAPID - 1);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(NUM_SLOTS - 1);

    logic [CD_W-1:0]      cooldown;
    logic [SW-1:0]        ptr;
    logic [NUM_SLOTS-1:0] last_mask;   // deploy vector of the previous frame clk
    logic [SW-1:0]        sel;
    logic                 sel_ok;
    logic [NUM_SLOTS-1:0] sel_vec;
    logic                 service;
    logic                 full;
    int                   idx;
    logic [SW-1:0]        idx_s;

    // Slot select. The scan runs from the farthest offset down to offset 0,
    // so the last qualifying hit is the one nearest to ptr.
    // last_mask masks a slot deployed on the previous frame clk, because its
    // busy flag may not have risen yet.
    always_comb begin
        sel    = ptr;
        sel_ok = 1'b0;
        idx    = 0;
        idx_s  = '0;
        if (MODE == 0) begin
            sel_ok = 1'b1;
        end else begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
                idx_s = SW'(idx);
                if (!slot_busy[idx_s] && !last_mask[idx_s]) begin
                    sel    = idx_s;
                    sel_ok = 1'b1;
                end
            end
        end
    end

    assign sel_vec         = NUM_SLOTS'(1) << sel;
    assign full            = (pending_cnt == PEND_MAX);
    assign service         = startOfFrame && enable && (cooldown == '0) &&
                             (pending_cnt != '0) && sel_ok;
    assign cooldown_active = (cooldown != '0);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            deploy      <= '0;
            pending_cnt <= '0;
            dropped     <= 1'b0;
            cooldown    <= '0;
            ptr         <= '0;
            last_mask   <= '0;
        end else begin
            deploy  <= service ? sel_vec : '0;
            // A request that arrives on a servicing clk takes the freed place, so it is never dropped.
            dropped <= enable && request && full && !service;

            if (!enable)
                pending_cnt <= '0;
            else if (request && !full && !service)
                pending_cnt <= pending_cnt + 1'b1;
            else if (service && !request)
                pending_cnt <= pending_cnt - 1'b1;

            if (startOfFrame) begin
                last_mask <= service ? sel_vec : '0;
                // The load is COOLDOWN-1, so a deploy falls on every COOLDOWN-th frame.
                if (cooldown != '0)
                    cooldown <= cooldown - 1'b1;
                else if (service)
                    cooldown <= rapid ? LOAD_R : LOAD_N;
            end

            if (service)
                ptr <= (sel == LAST_SLOT) ? '0 : sel + 1'b1;
        end
    end
endmodule

// File: tb/tb_deploy_scheduler.sv
module tb_deploy_scheduler;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       request = 1'b0;
    logic       rapid = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] slot_busy = 8'h00;
    logic [7:0] deploy;
    logic [2:0] pending_cnt;
    logic       dropped;
    logic       cooldown_active;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] vec;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    deploy_scheduler #(
        .NUM_SLOTS(8), .QUEUE_DEPTH(4), .CD_W(8),
        .COOLDOWN_NORMAL(50), .COOLDOWN_RAPID(20), .MODE(1)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .request(request),
        .rapid(rapid), .enable(enable), .slot_busy(slot_busy), .deploy(deploy),
        .pending_cnt(pending_cnt), .dropped(dropped), .cooldown_active(cooldown_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every expected deploy carries the exact cycle it must show on.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("deploy_missed", 32'h0, {24'h0, sb[0].vec});
            void'(sb.pop_front());
        end
        if (deploy != 8'h00) begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                chk("deploy_vec", {24'h0, deploy}, {24'h0, sb[0].vec});
                void'(sb.pop_front());
            end else begin
                chk("deploy_unexp", {24'h0, deploy}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; request = 1'b0; startOfFrame = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    task automatic req();
        request = 1'b1;
        tick();
        request = 1'b0;
    endtask

    // One frame: a frame clk followed by three idle clks. exp != 0 queues an expected deploy.
    task automatic frame(input logic [7:0] exp);
        if (exp != 8'h00) sb.push_back('{vec: exp, cyc: cyc + 1});
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic idle_frames(input int n);
        for (int k = 0; k < n; k++) frame(8'h00);
    endtask

    initial begin
        // 1: reset state, single request, first deploy
        repeat (2) tick();
        do_reset();
        chk("rst_deploy", {24'h0, deploy}, 32'h0);
        chk("rst_pending", {29'h0, pending_cnt}, 32'd0);
        chk("rst_dropped", {31'h0, dropped}, 32'd0);
        chk("rst_cd", {31'h0, cooldown_active}, 32'd0);
        repeat (3) tick();
        req();
        chk("t1_pend1", {29'h0, pending_cnt}, 32'd1);
        frame(8'h01);
        chk("t1_pend0", {29'h0, pending_cnt}, 32'd0);
        chk("t1_cd_on", {31'h0, cooldown_active}, 32'd1);

        // 2: spacing 50 with rotation; a mid-cooldown rapid change only affects the next load
        req();
        idle_frames(49);
        chk("t2_cd_off", {31'h0, cooldown_active}, 32'd0);
        frame(8'h02);
        req();
        idle_frames(9);
        rapid = 1'b1;
        idle_frames(40);
        frame(8'h04);
        req();
        idle_frames(19);
        frame(8'h08);
        rapid = 1'b0;
        chk("t2_cd_on", {31'h0, cooldown_active}, 32'd1);

        // 6b: reset mid-cooldown clears it; a deploy is possible on the next frame
        do_reset();
        chk("t6_rst_cd", {31'h0, cooldown_active}, 32'd0);
        chk("t6_rst_pend", {29'h0, pending_cnt}, 32'd0);

        // 3: first-free selection, then all busy -> held until a slot frees
        slot_busy = 8'b1111_0111;
        req();
        frame(8'h08);
        do_reset();
        slot_busy = 8'hFF;
        req();
        frame(8'h00);
        chk("t3_held_pend", {29'h0, pending_cnt}, 32'd1);
        chk("t3_held_cd", {31'h0, cooldown_active}, 32'd0);
        frame(8'h00);
        slot_busy = 8'hFB;
        frame(8'h04);
        chk("t3_pend0", {29'h0, pending_cnt}, 32'd0);

        // 5: wrap from ptr=7 past a busy slot 7 to slot 0, then ptr=1
        do_reset();
        slot_busy = 8'h3F;
        req();
        frame(8'h40);
        slot_busy = 8'h80;
        req();
        idle_frames(49);
        frame(8'h01);
        slot_busy = 8'h00;
        req();
        idle_frames(49);
        frame(8'h02);

        // 4: saturation and drops, then a request on a servicing frame clk while full
        do_reset();
        for (int i = 0; i < 6; i++) begin
            request = 1'b1;
            tick();
            chk("t4_pend", {29'h0, pending_cnt}, (i < 4) ? i + 1 : 4);
            chk("t4_drop", {31'h0, dropped}, (i >= 4) ? 32'd1 : 32'd0);
        end
        request = 1'b0;
        tick();
        chk("t4_drop_clr", {31'h0, dropped}, 32'd0);
        sb.push_back('{vec: 8'h01, cyc: cyc + 1});
        request = 1'b1; startOfFrame = 1'b1;
        tick();
        request = 1'b0; startOfFrame = 1'b0;
        chk("t4_svc_pend", {29'h0, pending_cnt}, 32'd4);
        chk("t4_svc_drop", {31'h0, dropped}, 32'd0);
        tick();

        // 6a: enable=0 flushes the queue, ignores requests and suppresses deploys
        do_reset();
        repeat (3) req();
        chk("t6_pend3", {29'h0, pending_cnt}, 32'd3);
        enable = 1'b0;
        request = 1'b1;
        tick();
        chk("t6_flush", {29'h0, pending_cnt}, 32'd0);
        chk("t6_nodrop", {31'h0, dropped}, 32'd0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0; request = 1'b0;
        chk("t6_pend_dis", {29'h0, pending_cnt}, 32'd0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (4) tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
